// File: rtl/calc_pkg.sv
// Shared types and default widths for the BinaryCalculator serial result link.
// Used by the transmitter, the receiver and the bench.
package calc_pkg;
   localparam int CALC_INBITS     = 8;
   localparam int CALC_SBITS      = 4;
   localparam int CALC_HDRBITS    = 8;
   localparam int CALC_FRAME_BITS = CALC_HDRBITS + 3 * CALC_INBITS;
   localparam int CALC_BEATS      = CALC_FRAME_BITS / CALC_SBITS;

   typedef enum logic [1:0] {IDLE, SHIFT, DRAIN} rx_state_t;

   typedef struct packed {
      logic [CALC_HDRBITS-1:0] hdr;
      logic [CALC_INBITS-1:0]  a;
      logic [CALC_INBITS-1:0]  b;
      logic [CALC_INBITS-1:0]  result;
   } frame_t;
endpackage

// File: rtl/calc_edge_det.sv
// Registers the divided transmit clock and produces a one-cycle rising-edge strobe.
module calc_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic tx_clk,
   output logic tx_edge
);
   logic tx_clk_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) tx_clk_d <= 1'b0;
      else     tx_clk_d <= tx_clk;
   end

   assign tx_edge = tx_clk & ~tx_clk_d;
endmodule

// File: rtl/calc_frame_receiver.sv
// Receive endpoint of the calculator serial link: reassembles and length-checks frames.
// Optional CALC_RX_STATS_EN adds saturating FrameCnt / ErrCnt outputs.
module calc_frame_receiver
   import calc_pkg::*;
#(
   parameter int INBITS     = CALC_INBITS,
   parameter int SBITS      = CALC_SBITS,
   parameter int HDRBITS    = CALC_HDRBITS,
   parameter int FRAME_BITS = HDRBITS + 3 * INBITS,
   parameter int BEATS      = FRAME_BITS / SBITS
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               ClkTx,
   input  logic               DoutValid,
   input  logic [SBITS-1:0]   DataOut,
   output logic               RxBusy,
   output logic               FrameValid,
   output logic               FrameErr,
   output logic [HDRBITS-1:0] RxHeader,
   output logic [INBITS-1:0]  RxA,
   output logic [INBITS-1:0]  RxB,
   output logic [INBITS-1:0]  RxResult
`ifdef CALC_RX_STATS_EN
   ,
   output logic [15:0]        FrameCnt,
   output logic [15:0]        ErrCnt
`endif
);
   localparam int CW = $clog2(BEATS + 1);

   rx_state_t             state, state_nx;
   logic [CW-1:0]         count, count_nx;
   logic [FRAME_BITS-1:0] shift, shift_nx, shift_in;
   logic                  ovr, ovr_nx;
   logic                  fire_valid, fire_err;
   logic                  tx_edge;

   calc_edge_det u_edge (
      .clk     (Clk),
      .rst     (Reset),
      .tx_clk  (ClkTx),
      .tx_edge (tx_edge)
   );

   assign RxBusy   = (state != IDLE);
   assign shift_in = {shift[FRAME_BITS-SBITS-1:0], DataOut};

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
         count <= '0;
         shift <= '0;
         ovr   <= 1'b0;
      end else begin
         state <= state_nx;
         count <= count_nx;
         shift <= shift_nx;
         ovr   <= ovr_nx;
      end
   end

   // The final beat is decoded straight from the incoming lane so FrameValid
   // lands one Clk after the edge that carried it.
   always_comb begin
      state_nx   = state;
      count_nx   = count;
      shift_nx   = shift;
      ovr_nx     = ovr;
      fire_valid = 1'b0;
      fire_err   = 1'b0;
      if (tx_edge) begin
         case (state)
            IDLE: if (DoutValid) begin
               shift_nx = shift_in;
               count_nx = CW'(1);
               state_nx = SHIFT;
            end
            SHIFT: if (DoutValid) begin
               shift_nx = shift_in;
               count_nx = count + 1'b1;
               if (count == CW'(BEATS - 1)) begin
                  fire_valid = 1'b1;
                  state_nx   = DRAIN;
               end
            end else begin
               fire_err = 1'b1;
               count_nx = '0;
               state_nx = IDLE;
            end
            DRAIN: if (DoutValid) begin
               // Only the first extra beat of a burst is flagged.
               fire_err = ~ovr;
               ovr_nx   = 1'b1;
            end else begin
               ovr_nx   = 1'b0;
               count_nx = '0;
               state_nx = IDLE;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         FrameValid <= 1'b0;
         FrameErr   <= 1'b0;
         RxHeader   <= '0;
         RxA        <= '0;
         RxB        <= '0;
         RxResult   <= '0;
      end else begin
         FrameValid <= fire_valid;
         FrameErr   <= fire_err;
         if (fire_valid) {RxHeader, RxA, RxB, RxResult} <= shift_nx;
      end
   end

`ifdef CALC_RX_STATS_EN
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         FrameCnt <= '0;
         ErrCnt   <= '0;
      end else begin
         if (fire_valid && FrameCnt != 16'hFFFF) FrameCnt <= FrameCnt + 16'd1;
         if (fire_err && ErrCnt != 16'hFFFF)     ErrCnt   <= ErrCnt + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_calc_frame_receiver.sv
// Scoreboard bench for calc_frame_receiver; expected frames queue on send, pop on FrameValid.
module tb_calc_frame_receiver;
   import calc_pkg::*;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       ClkTx = 1'b0;
   logic       DoutValid = 1'b0;
   logic [3:0] DataOut = '0;
   logic       RxBusy, FrameValid, FrameErr;
   logic [7:0] RxHeader, RxA, RxB, RxResult;
`ifdef CALC_RX_STATS_EN
   logic [15:0] FrameCnt, ErrCnt;
`endif

   int checks = 0;
   int errors = 0;
   int valid_seen = 0;
   int err_seen = 0;
   frame_t exp_q[$];

   calc_frame_receiver dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .ClkTx      (ClkTx),
      .DoutValid  (DoutValid),
      .DataOut    (DataOut),
      .RxBusy     (RxBusy),
      .FrameValid (FrameValid),
      .FrameErr   (FrameErr),
      .RxHeader   (RxHeader),
      .RxA        (RxA),
      .RxB        (RxB),
      .RxResult   (RxResult)
`ifdef CALC_RX_STATS_EN
      ,
      .FrameCnt   (FrameCnt),
      .ErrCnt     (ErrCnt)
`endif
   );

   always #5 Clk = ~Clk;

   // Scoreboard: every FrameValid pops one expected frame.
   always @(negedge Clk) begin
      if (!Reset) begin
         if (FrameValid && FrameErr) begin
            checks++; errors++;
            $display("FAIL strobe_overlap: FrameValid and FrameErr both high");
         end
         if (FrameErr) err_seen++;
         if (FrameValid) begin
            valid_seen++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_frame: got %h, none expected", {RxHeader, RxA, RxB, RxResult});
            end else begin
               frame_t e;
               e = exp_q.pop_front();
               if ({RxHeader, RxA, RxB, RxResult} !== e) begin
                  errors++;
                  $display("FAIL frame_fields: got %h expected %h", {RxHeader, RxA, RxB, RxResult}, e);
               end
            end
         end
      end
   end

   // One ClkTx period; lat=1 checks FrameValid rises exactly one Clk after this edge.
   task automatic beat(input logic dv, input logic [3:0] d, input int div, input bit lat);
      @(negedge Clk);
      ClkTx = 1'b1; DoutValid = dv; DataOut = d;
      if (lat) begin
         checks++;
         if (FrameValid !== 1'b0) begin
            errors++; $display("FAIL latency_early: FrameValid=%b expected 0", FrameValid);
         end
         @(posedge Clk); #1;
         checks++;
         if (FrameValid !== 1'b1) begin
            errors++; $display("FAIL latency: FrameValid=%b expected 1", FrameValid);
         end
      end
      repeat (div / 2) @(negedge Clk);
      ClkTx = 1'b0;
      repeat (div - div / 2 - 1) @(negedge Clk);
   endtask

   task automatic send_frame(input frame_t f, input int div, input bit lat);
      logic [31:0] bits;
      bits = f;
      exp_q.push_back(f);
      for (int i = 0; i < 8; i++) beat(1'b1, bits[31 - 4 * i -: 4], div, lat && (i == 7));
   endtask

   task automatic test_reset;
      #1;
      checks++;
      if ({RxBusy, FrameValid, FrameErr, RxHeader, RxA, RxB, RxResult} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected 0", {RxBusy, FrameValid, FrameErr, RxHeader, RxA, RxB, RxResult});
      end
`ifdef CALC_RX_STATS_EN
      checks++;
      if ({FrameCnt, ErrCnt} !== 32'h0) begin
         errors++; $display("FAIL reset_stats: got %h expected 0", {FrameCnt, ErrCnt});
      end
`endif
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
   endtask

   task automatic test_nominal(input int div);
      int v0, e0;
      v0 = valid_seen; e0 = err_seen;
      send_frame({8'h31, 8'h05, 8'h03, 8'h08}, div, 1'b1);
      beat(1'b0, 4'h0, div, 1'b0);
      checks++;
      if (valid_seen - v0 !== 1 || err_seen - e0 !== 0) begin
         errors++; $display("FAIL nominal_strobes_div%0d: valid=%0d err=%0d expected 1/0", div, valid_seen - v0, err_seen - e0);
      end
      checks++;
      if ({RxHeader, RxA, RxB, RxResult} !== 32'h31050308) begin
         errors++; $display("FAIL nominal_hold_div%0d: got %h expected 31050308", div, {RxHeader, RxA, RxB, RxResult});
      end
      checks++;
      if (RxBusy !== 1'b0) begin
         errors++; $display("FAIL nominal_idle_div%0d: RxBusy=%b expected 0", div, RxBusy);
      end
   endtask

   task automatic test_short;
      int v0, e0;
      logic [3:0] nib [5] = '{4'h9, 4'h8, 4'h7, 4'h6, 4'h5};
      v0 = valid_seen; e0 = err_seen;
      foreach (nib[i]) beat(1'b1, nib[i], 4, 1'b0);
      checks++;
      if (RxBusy !== 1'b1) begin
         errors++; $display("FAIL short_busy: RxBusy=%b expected 1", RxBusy);
      end
      beat(1'b0, 4'h0, 4, 1'b0);
      checks++;
      if (err_seen - e0 !== 1 || valid_seen - v0 !== 0) begin
         errors++; $display("FAIL short_strobes: err=%0d valid=%0d expected 1/0", err_seen - e0, valid_seen - v0);
      end
      checks++;
      if ({RxHeader, RxA, RxB, RxResult} !== 32'h31050308 || RxBusy !== 1'b0) begin
         errors++; $display("FAIL short_hold: got %h busy=%b expected 31050308 busy=0", {RxHeader, RxA, RxB, RxResult}, RxBusy);
      end
   endtask

   task automatic test_overrun;
      int v0, e0;
      v0 = valid_seen; e0 = err_seen;
      send_frame({8'h12, 8'h34, 8'h56, 8'h78}, 4, 1'b1);
      beat(1'b1, 4'hA, 4, 1'b0);
      checks++;
      if (err_seen - e0 !== 1) begin
         errors++; $display("FAIL overrun_first: err=%0d expected 1", err_seen - e0);
      end
      beat(1'b1, 4'hB, 4, 1'b0);
      checks++;
      if (err_seen - e0 !== 1 || valid_seen - v0 !== 1) begin
         errors++; $display("FAIL overrun_once: err=%0d valid=%0d expected 1/1", err_seen - e0, valid_seen - v0);
      end
      checks++;
      if ({RxHeader, RxA, RxB, RxResult} !== 32'h12345678 || RxBusy !== 1'b1) begin
         errors++; $display("FAIL overrun_drain: got %h busy=%b expected 12345678 busy=1", {RxHeader, RxA, RxB, RxResult}, RxBusy);
      end
      beat(1'b0, 4'h0, 4, 1'b0);
      checks++;
      if (RxBusy !== 1'b0) begin
         errors++; $display("FAIL overrun_idle: RxBusy=%b expected 0", RxBusy);
      end
   endtask

   task automatic test_reset_mid;
      int v0, e0;
      for (int i = 0; i < 4; i++) beat(1'b1, 4'hF, 4, 1'b0);
      @(posedge Clk); #3;
      Reset = 1'b1;
      #1;
      checks++;
      if ({RxBusy, FrameValid, FrameErr, RxHeader, RxA, RxB, RxResult} !== '0) begin
         errors++;
         $display("FAIL reset_mid_outputs: got %h expected 0", {RxBusy, FrameValid, FrameErr, RxHeader, RxA, RxB, RxResult});
      end
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      v0 = valid_seen; e0 = err_seen;
      send_frame({8'h9C, 8'hAA, 8'h55, 8'hFF}, 4, 1'b1);
      beat(1'b0, 4'h0, 4, 1'b0);
      checks++;
      if (valid_seen - v0 !== 1 || err_seen - e0 !== 0) begin
         errors++; $display("FAIL reset_mid_recover: valid=%0d err=%0d expected 1/0", valid_seen - v0, err_seen - e0);
      end
   endtask

   task automatic test_back_to_back;
      int v0, e0;
      @(negedge Clk); Reset = 1'b1;
      @(negedge Clk); Reset = 1'b0;
      v0 = valid_seen; e0 = err_seen;
      send_frame({8'h31, 8'h05, 8'h03, 8'h08}, 4, 1'b0);
      beat(1'b0, 4'h0, 4, 1'b0);
      send_frame({8'hC3, 8'h7F, 8'h80, 8'hFF}, 4, 1'b1);
      beat(1'b0, 4'h0, 4, 1'b0);
      checks++;
      if (valid_seen - v0 !== 2 || err_seen - e0 !== 0) begin
         errors++; $display("FAIL b2b_strobes: valid=%0d err=%0d expected 2/0", valid_seen - v0, err_seen - e0);
      end
`ifdef CALC_RX_STATS_EN
      checks++;
      if (FrameCnt !== 16'd2 || ErrCnt !== 16'd0) begin
         errors++; $display("FAIL b2b_stats: FrameCnt=%0d ErrCnt=%0d expected 2/0", FrameCnt, ErrCnt);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_nominal(4);
      test_short();
      test_overrun();
      test_reset_mid();
      test_back_to_back();
      test_nominal(16);
      repeat (4) @(negedge Clk);
      checks++;
      if (exp_q.size() !== 0) begin
         errors++; $display("FAIL scoreboard_drain: %0d frames never arrived", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/calc_frame_receiver.md
Name: calc_frame_receiver

Overview:
- Receive-side endpoint of the BinaryCalculator serial output link (DataOut / ClkTx / DoutValid).
- Samples the SBITS-wide lanes in the Clk domain on ClkTx rising edges and reassembles one result frame.
- Checks frame length, then presents decoded fields with a one-cycle FrameValid strobe.
- Sits beside the calculator in the top level, or in the bench as a checker front end.

Parameters:
- INBITS, 8, operand width; frame field width.
- SBITS, 4, serial lane width; must equal the transmitter's SBITS.
- HDRBITS, 8, header field width.
- FRAME_BITS, HDRBITS+3*INBITS (32), total frame length; must be divisible by SBITS.
- BEATS, FRAME_BITS/SBITS (8), lane transfers per frame.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- ClkTx  in  1  divided transmit clock from the calculator, synchronous to Clk.
- DoutValid  in  1  transmitter data-valid.
- DataOut  in  SBITS  serial lane data, MSB-first.
- RxBusy  out  1  high while a frame is in progress (SHIFT or DRAIN).
- FrameValid  out  1  one-Clk pulse when a frame of exactly BEATS beats is complete.
- FrameErr  out  1  one-Clk pulse on a short frame or an overrun.
- RxHeader  out  HDRBITS  frame bits [FRAME_BITS-1 -: HDRBITS].
- RxA  out  INBITS  next INBITS bits.
- RxB  out  INBITS  next INBITS bits.
- RxResult  out  INBITS  least-significant INBITS bits.

Behaviour:
- Reset (async, high): all outputs 0, state IDLE, beat count 0, shift register 0, ClkTx_d 0.
- Edge detect: ClkTx_d <= ClkTx each Clk. Beat strobe tx_edge = ClkTx & ~ClkTx_d.
- DoutValid and DataOut are sampled in the same Clk cycle as tx_edge.
- ClkTx high and low phases are each at least 1 Clk. Faster ClkTx is unsupported.
- Only tx_edge cycles affect the state machine; all other cycles hold state.
- IDLE:
  - tx_edge with DoutValid=1: shift = {shift[FRAME_BITS-SBITS-1:0], DataOut}, count=1, go to SHIFT.
  - tx_edge with DoutValid=0: no action.
- SHIFT:
  - tx_edge with DoutValid=1: shift in DataOut, count+1.
  - When count reaches BEATS: next Clk load RxHeader/RxA/RxB/RxResult from shift, pulse FrameValid, go to DRAIN.
  - Latency: FrameValid is high exactly 1 Clk after the tx_edge carrying beat BEATS.
  - tx_edge with DoutValid=0 and count<BEATS (short frame): pulse FrameErr, clear count, go to IDLE. Field outputs are not updated.
- DRAIN:
  - tx_edge with DoutValid=0: go to IDLE, clear count.
  - tx_edge with DoutValid=1 (overrun): pulse FrameErr once per overrun burst, discard data, stay in DRAIN.
  - Fields from the completed frame remain valid.
- Field outputs hold their value until the next FrameValid. They are undefined-free: 0 after reset.
- FrameValid and FrameErr are never high in the same cycle.
- Reset mid-frame: partial data is discarded, no strobe is produced, and the receiver restarts in IDLE.
- Back-to-back frames: DoutValid must drop for at least one ClkTx edge between frames. Without that gap, extra beats count as overrun.

Optional Feature:
- Macro: CALC_RX_STATS_EN.
- When defined, adds two outputs:
  - FrameCnt[15:0]: +1 per FrameValid.
  - ErrCnt[15:0]: +1 per FrameErr.
- Both counters saturate at 16'hFFFF and reset to 0.
- When not defined, neither port nor counter logic exists. Behaviour is otherwise identical.

Decomposition:
- Package calc_pkg holds:
  - rx_state_t enum {IDLE, SHIFT, DRAIN};
  - frame_t packed struct {hdr, a, b, result};
  - localparam default FRAME_BITS and BEATS.
- Shared with the transmitter and the bench.
- One natural sub-module: calc_edge_det (ClkTx register and rising-edge strobe). Shift, count and FSM stay in the top.

Test Plan:
- Nominal frame: with ClkTx = Clk/4, send nibbles 3,1,0,5,0,3,0,8 with DoutValid=1, then drop DoutValid. Expect FrameValid pulse 1 Clk after the 8th edge, RxHeader=0x31, RxA=0x05, RxB=0x03, RxResult=0x08, FrameErr=0.
- Short frame: send 5 beats, then DoutValid=0 at an edge. Expect FrameErr pulse, no FrameValid, fields keep previous values (0x31/05/03/08), RxBusy falls.
- Overrun: send 10 beats continuously. Expect FrameValid after beat 8, a single FrameErr at beat 9, none at beat 10, and IDLE after DoutValid drops.
- Reset mid-frame: assert Reset asynchronously after beat 4. Expect all outputs 0 immediately. Then a full frame A=0xAA, B=0x55 decodes correctly with no spurious strobe.
- Back-to-back: two frames (results 0x08, then 0xFF) separated by one idle edge. Expect two FrameValid pulses with correct fields each. With CALC_RX_STATS_EN, FrameCnt=2 and ErrCnt=0.
- Slow link: ClkTx = Clk/16 with DoutValid toggling only at edges. Expect decode identical to the nominal case; no action on non-edge cycles.
